sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Two-requester arbiter and sequencer in front of one sram32 macro. It shares the single SRAM port between requesters A and B using round-robin arbitration with a valid/ready handshake. Read data is returned with fixed one-cycle latency. An optional clear engine zero-fills the whole array after reset, so DMA/CPU-side masters never read uninitialised SRAM.

Parameters:
AW, 10, SRAM word-address width; depth = 2**AW words of 32 bits.
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset before accepting requests; 0 = skip clear.

Ports:
HCLK  input  1  clock; SRAM also clocked by HCLK.
HRESET  input  1  asynchronous, active-high reset.
a_valid  input  1  requester A request valid.
a_ready  output  1  A request accepted this cycle (valid & ready).
a_wen  input  4  A byte write enables; 4'h0 = read.
a_addr  input  AW  A word address.
a_wdata  input  32  A write data.
a_rvalid  output  1  A read data valid.
a_rdata  output  32  A read data.
b_valid, b_ready, b_wen, b_addr, b_wdata, b_rvalid, b_rdata: identical set for requester B.
SRAMCS  output  1  SRAM chip select.
SRAMWEN  output  4  SRAM byte write enables.
SRAMADDR  output  AW  SRAM address.
SRAMWDATA  output  32  SRAM write data.
SRAMRDATA  input  32  SRAM read data, valid the cycle after a read access.
init_done  output  1  high once clear is complete (or immediately if CLEAR_ON_RESET=0).

Behaviour:
- Reset values: state = CLEAR if CLEAR_ON_RESET else RUN; clr_addr = 0; rr_ptr = A; init_done = !CLEAR_ON_RESET; a_rvalid = b_rvalid = 0.
- Reset mid-operation aborts any clear or read in flight. No rvalid is issued for an aborted access, and the clear restarts from address 0.
- State CLEAR:
  - Drives SRAMCS=1, SRAMWEN=4'hF, SRAMWDATA=0, SRAMADDR=clr_addr every cycle.
  - a_ready = b_ready = 0.
  - clr_addr increments each cycle. On clr_addr == 2**AW-1 the FSM moves to RUN and init_done is registered to 1.
  - Clear takes exactly 2**AW cycles.
- State RUN, arbitration:
  - Combinational grant. Only A valid: A. Only B valid: B. Both valid: the requester pointed to by rr_ptr.
  - x_ready = grant to x. The ready of the ungranted requester is 0.
  - On any accepted request, rr_ptr <= the other requester. With no request, rr_ptr holds.
  - Two continuously valid requesters therefore alternate A,B,A,B; no starvation.
- RUN, SRAM drive: SRAMCS = any grant. SRAMWEN, SRAMADDR and SRAMWDATA are muxed from the granted requester. With no grant, SRAMCS=0 and the other outputs are 0.
- Reads (wen==0):
  - The accepted read sets a registered pending flag plus the requester id.
  - Next cycle, x_rvalid=1 for exactly one cycle and x_rdata = SRAMRDATA.
  - x_rdata = 0 whenever x_rvalid=0.
- Writes produce no response. Partial writes modify only the enabled bytes.
- Back-to-back: one access per cycle, full throughput. A read accepted in the cycle after a write to the same address returns the new data.
- Requesters must hold valid and payload stable until ready. The arbiter does not buffer.
- Address width: addresses are used verbatim. There is no wrap logic; SRAMADDR is exactly AW bits.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {CLEAR, RUN};
  - requester id constants REQ_A=0, REQ_B=1;
  - WEN_READ = 4'h0, WEN_FULL = 4'hF.
- One natural sub-module, rr_arbiter2: a two-way round-robin grant with pointer register. Inputs: req[1:0], accept. Outputs: gnt[1:0].
- The clear FSM, mux and read-return pipeline stay in the top.

Test Plan:
- Clear with AW=4, CLEAR_ON_RESET=1 -> exactly 16 cycles of SRAMCS=1, SRAMWEN=F, addresses 0..15; init_done rises after the 16th; a_ready stays 0 throughout. A read of addr 7 then returns 32'h0.
- A writes 32'h44332211 to addr 0, then reads addr 0 -> a_rvalid one cycle after acceptance with a_rdata=32'h44332211; b_rvalid stays 0.
- Byte write: A writes wen=4'b0010, data 32'h0000AB00 to addr 0 (holding 32'h44332211); read back -> 32'h4433AB11.
- Contention: A and B both valid for 4 cycles, reads of addrs 1 and 2 -> grants alternate starting from rr_ptr (A first after reset); each requester gets 2 rvalid pulses with its own data; no cycle has both readys high.
- Write then read: B writes 32'hDEADBEEF to addr 3'h5; in the next cycle A reads addr 5 -> a_rdata=32'hDEADBEEF.
- Async reset asserted mid-clear (cycle 5) and mid-read -> all rvalid drop immediately, init_done=0; after release the clear restarts at address 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Holds the sequencer state encoding, requester ids and write-enable codes.
package sram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [3:0] WEN_READ = 4'h0;
  localparam logic [3:0] WEN_FULL = 4'hF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the requester that wins a tie
// and flips to the other side after every accepted request.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_reg;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_reg == REQ_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ptr_reg <= REQ_A;
    end else if (accept && (gnt != 2'b00)) begin
      ptr_reg <= gnt[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram32 port between requesters A and B with round-robin grant,
// one-cycle read return, and an optional zero-fill of the array after reset.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW             = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESET,

  input  logic          a_valid,
  output logic          a_ready,
  input  logic [3:0]    a_wen,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,

  input  logic          b_valid,
  output logic          b_ready,
  input  logic [3:0]    b_wen,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,

  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  input  logic [31:0]   SRAMRDATA,

  output logic          init_done
);

  localparam logic [AW-1:0] CLR_LAST = '1;

  state_t        state_reg;
  logic [AW-1:0] clr_addr_reg;
  logic          init_done_reg;
  logic          rd_pend_reg;
  logic          rd_id_reg;

  logic          run;
  logic [1:0]    gnt;
  logic [1:0]    rvalid_vec;
  logic [31:0]   rdata_vec [2];

  assign run       = (state_reg == RUN);
  assign init_done = init_done_reg;

  // Requests are masked while clearing so the pointer cannot move before RUN.
  rr_arbiter2 u_rr (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .req    ({b_valid, a_valid} & {2{run}}),
    .accept (run),
    .gnt    (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = WEN_READ;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    if (!run) begin
      SRAMCS   = 1'b1;
      SRAMWEN  = WEN_FULL;
      SRAMADDR = clr_addr_reg;
    end else if (gnt[0]) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = a_wen;
      SRAMADDR  = a_addr;
      SRAMWDATA = a_wdata;
    end else if (gnt[1]) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = b_wen;
      SRAMADDR  = b_addr;
      SRAMWDATA = b_wdata;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_addr_reg  <= '0;
      init_done_reg <= !CLEAR_ON_RESET;
    end else if (!run) begin
      clr_addr_reg <= clr_addr_reg + 1'b1;
      if (clr_addr_reg == CLR_LAST) begin
        state_reg     <= RUN;
        init_done_reg <= 1'b1;
      end
    end
  end

  // Read return: the SRAM answers one cycle after the accepted read.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_pend_reg <= 1'b0;
      rd_id_reg   <= REQ_A;
    end else begin
      rd_pend_reg <= (gnt != 2'b00) && (SRAMWEN == WEN_READ);
      if (gnt != 2'b00) begin
        rd_id_reg <= gnt[1] ? REQ_B : REQ_A;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign rvalid_vec[gi] = rd_pend_reg && (rd_id_reg == 1'(gi));
    assign rdata_vec[gi]  = rvalid_vec[gi] ? SRAMRDATA : 32'h0;
  end

  assign a_rvalid = rvalid_vec[0];
  assign b_rvalid = rvalid_vec[1];
  assign a_rdata  = rdata_vec[0];
  assign b_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with AW=4 and a behavioural sram32 model.
// Table vectors cover arbitration and data; hand sequences cover clear and reset.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  localparam int AW = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [3:0]    a_wen, b_wen;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;
  logic          a_rvalid, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [31:0]   SRAMRDATA;
  logic          init_done;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  sram_port_arbiter #(.AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_wen     (a_wen),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_wen     (b_wen),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .SRAMCS    (SRAMCS),
    .SRAMWEN   (SRAMWEN),
    .SRAMADDR  (SRAMADDR),
    .SRAMWDATA (SRAMWDATA),
    .SRAMRDATA (SRAMRDATA),
    .init_done (init_done)
  );

  // sram32 model, pre-filled with non-zero junk so the clear is observable
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hBAD0_0000 + i;
    SRAMRDATA = 32'h0;
  end

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'h0) begin
        SRAMRDATA <= mem[SRAMADDR];
      end else begin
        for (int k = 0; k < 4; k++)
          if (SRAMWEN[k]) mem[SRAMADDR][8*k +: 8] <= SRAMWDATA[8*k +: 8];
      end
    end
  end

  typedef struct {
    logic        av;
    logic [3:0]  awen;
    logic [3:0]  aaddr;
    logic [31:0] awdata;
    logic        bv;
    logic [3:0]  bwen;
    logic [3:0]  baddr;
    logic [31:0] bwdata;
    logic        ea_rdy;
    logic        eb_rdy;
    logic        ea_rv;
    logic [31:0] ea_rd;
    logic        eb_rv;
    logic [31:0] eb_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply_vec(input int idx, input vec_t v);
    logic        ecs;
    logic [3:0]  ewen;
    logic [3:0]  eaddr;
    logic [31:0] ewdata;
    a_valid = v.av; a_wen = v.awen; a_addr = v.aaddr; a_wdata = v.awdata;
    b_valid = v.bv; b_wen = v.bwen; b_addr = v.baddr; b_wdata = v.bwdata;
    ecs = 1'b0; ewen = 4'h0; eaddr = 4'h0; ewdata = 32'h0;
    if (v.ea_rdy) begin
      ecs = 1'b1; ewen = v.awen; eaddr = v.aaddr; ewdata = v.awdata;
    end else if (v.eb_rdy) begin
      ecs = 1'b1; ewen = v.bwen; eaddr = v.baddr; ewdata = v.bwdata;
    end
    #1;
    chk("a_ready", 32'(a_ready), 32'(v.ea_rdy));
    chk("b_ready", 32'(b_ready), 32'(v.eb_rdy));
    chk("SRAMCS", 32'(SRAMCS), 32'(ecs));
    chk("SRAMWEN", 32'(SRAMWEN), 32'(ewen));
    chk("SRAMADDR", 32'(SRAMADDR), 32'(eaddr));
    chk("SRAMWDATA", SRAMWDATA, ewdata);
    @(posedge HCLK); #1;
    chk("a_rvalid", 32'(a_rvalid), 32'(v.ea_rv));
    chk("a_rdata", a_rdata, v.ea_rd);
    chk("b_rvalid", 32'(b_rvalid), 32'(v.eb_rv));
    chk("b_rdata", b_rdata, v.eb_rd);
    $display("vec %0d: a_rdy=%0b b_rdy=%0b a_rv=%0b a_rd=%h b_rv=%0b b_rd=%h",
             idx, v.ea_rdy, v.eb_rdy, a_rvalid, a_rdata, b_rvalid, b_rdata);
    @(negedge HCLK);
  endtask

  // Called at a negedge with reset released; checks n clear cycles.
  task automatic check_clear(input int n);
    a_valid = 1'b1; b_valid = 1'b1; a_wen = 4'h0; b_wen = 4'h0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("clr_cs", 32'(SRAMCS), 32'h1);
      chk("clr_wen", 32'(SRAMWEN), 32'hF);
      chk("clr_addr", 32'(SRAMADDR), 32'(i));
      chk("clr_wdata", SRAMWDATA, 32'h0);
      chk("clr_a_ready", 32'(a_ready), 32'h0);
      chk("clr_b_ready", 32'(b_ready), 32'h0);
      chk("clr_init_done", 32'(init_done), 32'h0);
      $display("clear cycle %0d: addr=%0d cs=%0b", i, SRAMADDR, SRAMCS);
      @(negedge HCLK);
    end
  endtask

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //             av  awen  aa    awdata        bv  bwen  ba    bwdata        ar bar arv ard           brv brd
    vecs[0]  = '{1'b1, 4'h0, 4'h7, 32'h0,        1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'hF, 4'h0, 32'h44332211, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 4'h0, 4'h0, 32'h0,        1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h44332211, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 4'h2, 4'h0, 32'h0000AB00, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 4'h0, 32'h0,        1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h4433AB11, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'hF, 4'h1, 32'h11111111, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 4'hF, 4'h2, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    // contention: pointer is back at A after B's write
    vecs[7]  = '{1'b1, 4'h0, 4'h1, 32'h0,        1'b1, 4'h0, 4'h2, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 4'h0, 4'h1, 32'h0,        1'b1, 4'h0, 4'h2, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222};
    vecs[9]  = '{1'b1, 4'h0, 4'h1, 32'h0,        1'b1, 4'h0, 4'h2, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 4'h0, 4'h1, 32'h0,        1'b1, 4'h0, 4'h2, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222};
    vecs[11] = '{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 4'hF, 4'h5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b1, 4'h0, 4'h5, 32'h0,        1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    // idle holds the pointer at B, so the next tie goes to B
    vecs[13] = '{1'b0, 4'h0, 4'h0, 32'h0,        1'b0, 4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b1, 4'h0, 4'h1, 32'h0,        1'b1, 4'h0, 4'h5, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};

    HRESET = 1'b1;
    a_valid = 1'b1; a_wen = 4'h0; a_addr = 4'h0; a_wdata = 32'h0;
    b_valid = 1'b1; b_wen = 4'h0; b_addr = 4'h0; b_wdata = 32'h0;
    #12;
    @(negedge HCLK);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'h0);
    chk("rst_a_ready", 32'(a_ready), 32'h0);
    chk("rst_sramaddr", 32'(SRAMADDR), 32'h0);
    HRESET = 1'b0;

    check_clear(16);
    chk("init_done_after_clear", 32'(init_done), 32'h1);

    for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

    // reset while a read response is being returned
    a_valid = 1'b1; a_wen = 4'h0; a_addr = 4'h0; b_valid = 1'b0;
    @(posedge HCLK); #1;
    chk("midread_a_rvalid", 32'(a_rvalid), 32'h1);
    chk("midread_a_rdata", a_rdata, 32'h4433AB11);
    a_valid = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("midread_rst_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("midread_rst_a_rdata", a_rdata, 32'h0);
    chk("midread_rst_b_rvalid", 32'(b_rvalid), 32'h0);
    chk("midread_rst_init_done", 32'(init_done), 32'h0);
    $display("reset asserted mid-read");
    @(negedge HCLK);
    HRESET = 1'b0;

    // reset five cycles into the clear, then the clear restarts at 0
    check_clear(5);
    #1;
    chk("midclr_addr_before", 32'(SRAMADDR), 32'h5);
    HRESET = 1'b1;
    #1;
    chk("midclr_rst_addr", 32'(SRAMADDR), 32'h0);
    chk("midclr_rst_init_done", 32'(init_done), 32'h0);
    $display("reset asserted mid-clear");
    @(negedge HCLK);
    HRESET = 1'b0;
    check_clear(16);
    chk("init_done_after_reclear", 32'(init_done), 32'h1);

    apply_vec(100, '{1'b1, 4'h0, 4'h5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0});
    apply_vec(101, '{1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0,
                     1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
